// File: rtl/leb128_fetch.sv
// rtl/leb128_fetch.sv - LEB128 immediate fetcher: reads bytes over a ready/enable
// handshake and decodes an unsigned or signed value of IMM_WIDTH bits.
module leb128_fetch #(
  parameter int IMM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IMM_WIDTH-1:0]  imm,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [3:0]            byte_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready
);

  localparam int MAX_BYTES = (IMM_WIDTH + 6) / 7;
  // Payload bits actually used by the final permitted byte.
  localparam int R = IMM_WIDTH - 7 * (MAX_BYTES - 1);
  localparam logic [13:0] UM_WIDE = 14'h007F << R;
  localparam logic [13:0] SM_WIDE = 14'h007F << (R - 1);
  localparam logic [6:0]  UMASK   = UM_WIDE[6:0];
  localparam logic [6:0]  SMASK   = SM_WIDE[6:0];
  localparam logic [3:0]  LAST_K  = 4'(MAX_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_REQ, S_RELEASE, S_DONE} state_t;

  state_t                state, state_n;
  logic [IMM_WIDTH-1:0]  acc, acc_n;
  logic [3:0]            k, k_n;
  logic                  err, err_n;
  logic                  fin, fin_n;
  logic                  sgn, sgn_n;
  logic [ADDR_WIDTH-1:0] pc_base, pc_base_n;
  logic                  busy_n, done_n, error_n, mem_read_en_n;
  logic [IMM_WIDTH-1:0]  imm_n;
  logic [ADDR_WIDTH-1:0] next_pc_n, mem_addr_n;
  logic [3:0]            byte_count_n;

  logic [6:0]            sh, sh1;
  logic [3:0]            k_inc;
  logic [IMM_WIDTH-1:0]  payload, acc_upd, ext_mask, acc_fin;
  logic [6:0]            pad_u, pad_s;
  logic                  last_byte, at_last, pad_bad, err_byte;

  // Shifting within IMM_WIDTH drops payload bits that fall above the value width.
  assign k_inc     = k + 4'd1;
  assign sh        = 7'(k) * 7'd7;
  assign sh1       = 7'(k_inc) * 7'd7;
  assign payload   = {{(IMM_WIDTH-7){1'b0}}, mem_data[6:0]} << sh;
  assign acc_upd   = acc | payload;
  assign ext_mask  = {IMM_WIDTH{1'b1}} << sh1;
  assign last_byte = ~mem_data[7];
  assign at_last   = (k == LAST_K);
  assign pad_u     = mem_data[6:0] & UMASK;
  assign pad_s     = mem_data[6:0] & SMASK;
  assign pad_bad   = sgn ? ((pad_s != 7'd0) && (pad_s != SMASK)) : (pad_u != 7'd0);
  assign err_byte  = at_last & (mem_data[7] | pad_bad);
  assign acc_fin   = (sgn && last_byte && mem_data[6]) ? (acc_upd | ext_mask) : acc_upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      k           <= '0;
      err         <= 1'b0;
      fin         <= 1'b0;
      sgn         <= 1'b0;
      pc_base     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      imm         <= '0;
      next_pc     <= '0;
      byte_count  <= '0;
      mem_addr    <= '0;
      mem_read_en <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      k           <= k_n;
      err         <= err_n;
      fin         <= fin_n;
      sgn         <= sgn_n;
      pc_base     <= pc_base_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
      imm         <= imm_n;
      next_pc     <= next_pc_n;
      byte_count  <= byte_count_n;
      mem_addr    <= mem_addr_n;
      mem_read_en <= mem_read_en_n;
    end
  end

  always_comb begin
    state_n       = state;
    acc_n         = acc;
    k_n           = k;
    err_n         = err;
    fin_n         = fin;
    sgn_n         = sgn;
    pc_base_n     = pc_base;
    busy_n        = busy;
    done_n        = 1'b0;
    error_n       = error;
    imm_n         = imm;
    next_pc_n     = next_pc;
    byte_count_n  = byte_count;
    mem_addr_n    = mem_addr;
    mem_read_en_n = mem_read_en;
    case (state)
      S_IDLE: begin
        if (start) begin
          sgn_n     = signed_mode;
          pc_base_n = start_pc;
          acc_n     = '0;
          k_n       = '0;
          err_n     = 1'b0;
          fin_n     = 1'b0;
          busy_n    = 1'b1;
          // A ready left high by an earlier transfer must drop before a new request.
          if (mem_ready) begin
            state_n = S_DRAIN;
          end else begin
            state_n       = S_REQ;
            mem_addr_n    = start_pc;
            mem_read_en_n = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        mem_read_en_n = 1'b0;
        if (!mem_ready) begin
          state_n       = S_REQ;
          mem_addr_n    = pc_base;
          mem_read_en_n = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          acc_n         = acc_fin;
          k_n           = k_inc;
          err_n         = err_byte;
          fin_n         = last_byte | at_last;
          mem_read_en_n = 1'b0;
          state_n       = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!mem_ready) begin
          if (fin) begin
            state_n      = S_DONE;
            done_n       = 1'b1;
            error_n      = err;
            imm_n        = err ? '0 : acc;
            next_pc_n    = pc_base + ADDR_WIDTH'(k);
            byte_count_n = k;
          end else begin
            state_n       = S_REQ;
            mem_addr_n    = pc_base + ADDR_WIDTH'(k);
            mem_read_en_n = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_leb128_fetch.sv
// tb/tb_leb128_fetch.sv - bench for leb128_fetch at IMM_WIDTH 64 and 32 sharing one
// byte memory with configurable ready rise/fall delays.
module tb_leb128_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start64 = 1'b0, start32 = 1'b0, signed_mode = 1'b0;
  logic [31:0] start_pc = '0;
  logic        sel = 1'b0;

  logic        busy64, done64, err64, en64;
  logic [63:0] imm64;
  logic [31:0] npc64, addr64;
  logic [3:0]  bc64;
  logic        busy32, done32, err32, en32;
  logic [31:0] imm32;
  logic [31:0] npc32, addr32;
  logic [3:0]  bc32;

  logic [7:0]  mem [256];
  logic [7:0]  mem_data;
  logic        mem_ready = 1'b0;
  int          rise_extra = 0, fall_extra = 0, mcnt = 0;

  logic        cur_en, cur_done, cur_busy, cur_err;
  logic [31:0] cur_addr, cur_npc;
  logic [63:0] cur_imm;
  logic [3:0]  cur_bc;

  int n_chk = 0, n_fail = 0;
  int reads = 0, dones = 0, proto_bad = 0;
  logic prev_en = 1'b0;
  logic [79:0] cur_b;

  always #5 clk = ~clk;

  leb128_fetch #(.IMM_WIDTH(64), .ADDR_WIDTH(32)) u64 (
    .clk(clk), .rst(rst), .start(start64), .signed_mode(signed_mode), .start_pc(start_pc),
    .busy(busy64), .done(done64), .error(err64), .imm(imm64), .next_pc(npc64),
    .byte_count(bc64), .mem_addr(addr64), .mem_read_en(en64),
    .mem_data(mem_data), .mem_ready(mem_ready));

  leb128_fetch #(.IMM_WIDTH(32), .ADDR_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(signed_mode), .start_pc(start_pc),
    .busy(busy32), .done(done32), .error(err32), .imm(imm32), .next_pc(npc32),
    .byte_count(bc32), .mem_addr(addr32), .mem_read_en(en32),
    .mem_data(mem_data), .mem_ready(mem_ready));

  assign cur_en   = sel ? en32   : en64;
  assign cur_done = sel ? done32 : done64;
  assign cur_busy = sel ? busy32 : busy64;
  assign cur_err  = sel ? err32  : err64;
  assign cur_addr = sel ? addr32 : addr64;
  assign cur_npc  = sel ? npc32  : npc64;
  assign cur_bc   = sel ? bc32   : bc64;
  assign cur_imm  = sel ? {32'd0, imm32} : imm64;
  assign mem_data = mem[cur_addr[7:0]];

  // Memory: ready follows the read enable after 1 + extra cycles.
  always @(posedge clk) begin
    if (cur_en != mem_ready) begin
      if (mcnt >= (cur_en ? rise_extra : fall_extra)) begin
        mem_ready <= cur_en;
        mcnt      <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (cur_en && !prev_en) begin
      reads++;
      if (mem_ready) proto_bad++;
    end
    prev_en = cur_en;
    if (cur_done) dones++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference decode from cur_b using wide arithmetic and a value-range check.
  function automatic void model(input bit s32, input bit sg, input logic [31:0] pc, input int n,
                                output logic [63:0] imm, output logic err,
                                output logic [3:0] cnt, output logic [31:0] npc);
    int w, mb, c;
    logic [127:0] big, top;
    w = s32 ? 32 : 64;
    mb = (w + 6) / 7;
    big = '0; err = 1'b0; c = 0;
    for (int i = 0; i < n; i++) begin
      big |= {121'd0, cur_b[8*i+6 -: 7]} << (7*i);
      c = i + 1;
      if (!cur_b[8*i+7]) break;
      if (i == mb - 1) begin err = 1'b1; break; end
    end
    if (!err) begin
      if (sg && cur_b[8*(c-1)+6]) big |= ~128'd0 << (7*c);
      if (sg) begin
        top = big >> (w - 1);
        err = (top != 0) && (top != (~128'd0 >> (w - 1)));
      end else begin
        top = big >> w;
        err = (top != 0);
      end
    end
    imm = err ? 64'd0 : (s32 ? {32'd0, big[31:0]} : big[63:0]);
    cnt = 4'(c);
    npc = pc + 32'(c);
  endfunction

  task automatic run(input bit s32, input bit sg, input logic [31:0] pc, input int n,
                     input int pulse_cyc,
                     output logic [63:0] r_imm, output logic r_err, output logic [3:0] r_cnt,
                     output logic [31:0] r_npc, output int dcyc, output int r_reads,
                     output int r_dones, output logic r_busy);
    int r0, d0, cyc;
    bit got;
    for (int i = 0; i < n; i++) mem[8'(pc + 32'(i))] = cur_b[8*i +: 8];
    r0 = reads; d0 = dones;
    sel = s32; signed_mode = sg; start_pc = pc;
    if (s32) start32 = 1'b1; else start64 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; start64 = 1'b0;
    cyc = 1; got = 0; dcyc = 0;
    r_imm = '0; r_err = 1'b0; r_cnt = '0; r_npc = '0;
    while (!got && cyc < 2000) begin
      if (cur_done) begin
        got = 1; dcyc = cyc;
        r_imm = cur_imm; r_err = cur_err; r_cnt = cur_bc; r_npc = cur_npc;
      end else begin
        if (cyc == pulse_cyc) begin
          if (s32) start32 = 1'b1; else start64 = 1'b1;
        end else begin
          start32 = 1'b0; start64 = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start32 = 1'b0; start64 = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: actual no done in %0d cycles required done", cyc);
    end
    repeat (4) @(negedge clk);
    r_reads = reads - r0;
    r_dones = dones - d0;
    r_busy  = cur_busy;
  endtask

  typedef struct {
    bit          s32;
    bit          sg;
    logic [31:0] pc;
    int          n;
    logic [79:0] b;
    logic [63:0] imm;
    logic        err;
    int          cnt;
    logic [31:0] npc;
  } vec_t;

  vec_t tab [13];

  logic [63:0] g_imm, m_imm;
  logic        g_err, m_err, g_busy;
  logic [3:0]  g_cnt, m_cnt;
  logic [31:0] g_npc, m_npc;
  int          g_dcyc, g_reads, g_dones, t;
  bit          rs32, rsg;
  int          rw, rmb, rn;
  logic [7:0]  v;

  initial begin
    tab[0]  = '{0, 0, 32'h100, 3,  80'h268EE5, 64'h98765, 0, 3, 32'h103};
    tab[1]  = '{1, 1, 32'h200, 3,  80'h78BBC0, 64'hFFFE1DC0, 0, 3, 32'h203};
    tab[2]  = '{1, 1, 32'h10,  1,  80'h7F, 64'hFFFFFFFF, 0, 1, 32'h11};
    tab[3]  = '{1, 1, 32'h20,  1,  80'h3F, 64'h3F, 0, 1, 32'h21};
    tab[4]  = '{1, 0, 32'h30,  1,  80'h7F, 64'h7F, 0, 1, 32'h31};
    tab[5]  = '{1, 0, 32'h40,  5,  80'h0FFFFFFFFF, 64'hFFFFFFFF, 0, 5, 32'h45};
    tab[6]  = '{1, 0, 32'h50,  5,  80'h1FFFFFFFFF, 64'h0, 1, 5, 32'h55};
    tab[7]  = '{1, 0, 32'h60,  5,  80'hFFFFFFFFFF, 64'h0, 1, 5, 32'h65};
    tab[8]  = '{1, 0, 32'hFFFFFFFE, 3, 80'h018080, 64'h4000, 0, 3, 32'h1};
    tab[9]  = '{0, 1, 32'h70,  10, 80'h7FFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 10, 32'h7A};
    tab[10] = '{0, 1, 32'h90,  10, 80'h01FFFFFFFFFFFFFFFFFF, 64'h0, 1, 10, 32'h9A};
    tab[11] = '{0, 0, 32'hA0,  10, 80'h01FFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 10, 32'hAA};
    tab[12] = '{1, 1, 32'hB0,  2,  80'h7F80, 64'hFFFFFF80, 0, 2, 32'hB2};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ctrl", 64'({busy64, done64, err64, en64, busy32, done32, err32, en32}), 64'd0);
    chk("reset_imm", imm64 | {32'd0, imm32}, 64'd0);
    chk("reset_pc", {npc64, npc32}, 64'd0);
    chk("reset_addr", {addr64, addr32}, 64'd0);
    chk("reset_bc", 64'({bc64, bc32}), 64'd0);

    for (int i = 0; i < 13; i++) begin
      cur_b = tab[i].b;
      run(tab[i].s32, tab[i].sg, tab[i].pc, tab[i].n, 0,
          g_imm, g_err, g_cnt, g_npc, g_dcyc, g_reads, g_dones, g_busy);
      chk($sformatf("tab%0d_imm", i), g_imm, tab[i].imm);
      chk($sformatf("tab%0d_err", i), 64'(g_err), 64'(tab[i].err));
      chk($sformatf("tab%0d_cnt", i), 64'(g_cnt), 64'(tab[i].cnt));
      chk($sformatf("tab%0d_npc", i), 64'(g_npc), 64'(tab[i].npc));
      chk($sformatf("tab%0d_done_cycle", i), 64'(g_dcyc), 64'(4 * tab[i].n + 1));
      chk($sformatf("tab%0d_reads", i), 64'(g_reads), 64'(tab[i].cnt));
      chk($sformatf("tab%0d_dones", i), 64'(g_dones), 64'd1);
    end

    // Ready withheld 5 extra cycles per byte, plus a start pulsed while busy.
    rise_extra = 5;
    cur_b = tab[0].b;
    run(0, 0, 32'h100, 3, 6, g_imm, g_err, g_cnt, g_npc, g_dcyc, g_reads, g_dones, g_busy);
    chk("stall_imm", g_imm, 64'h98765);
    chk("stall_err", 64'(g_err), 64'd0);
    chk("stall_npc", 64'(g_npc), 64'h103);
    chk("stall_cnt", 64'(g_cnt), 64'd3);
    chk("stall_done_cycle", 64'(g_dcyc), 64'd28);
    chk("stall_dones", 64'(g_dones), 64'd1);
    chk("stall_reads", 64'(g_reads), 64'd3);
    chk("stall_idle_after", 64'(g_busy), 64'd0);
    rise_extra = 0;

    // Reset in RELEASE of byte 2 while ready is held high by a slow fall.
    fall_extra = 10;
    cur_b = 80'h0585;
    mem[8'h00] = 8'h85; mem[8'h01] = 8'h05;
    sel = 1'b0; signed_mode = 1'b0; start_pc = 32'h300;
    start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    t = 0;
    while (!(cur_en && cur_addr == 32'h301) && t < 200) begin @(negedge clk); t++; end
    while (cur_en && t < 200) begin @(negedge clk); t++; end
    chk("rst_reached_release2", 64'(t < 200), 64'd1);
    g_dones = dones;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_en_low", 64'(cur_en), 64'd0);
    chk("rst_busy_low", 64'(cur_busy), 64'd0);
    chk("rst_ready_still_high", 64'(mem_ready), 64'd1);
    @(negedge clk);
    chk("rst_no_done", 64'(dones - g_dones), 64'd0);
    cur_b = 80'h05;
    run(0, 0, 32'h310, 1, 0, g_imm, g_err, g_cnt, g_npc, g_dcyc, g_reads, g_dones, g_busy);
    chk("rst_drain_imm", g_imm, 64'd5);
    chk("rst_drain_cnt", 64'(g_cnt), 64'd1);
    chk("rst_drain_npc", 64'(g_npc), 64'h311);
    chk("rst_drain_delayed", 64'(g_dcyc > 5), 64'd1);
    fall_extra = 0;

    for (int it = 0; it < 40; it++) begin
      rs32 = 1'($urandom_range(0, 1));
      rsg  = 1'($urandom_range(0, 1));
      rw   = rs32 ? 32 : 64;
      rmb  = (rw + 6) / 7;
      rn   = $urandom_range(1, rmb);
      cur_b = '0;
      for (int i = 0; i < rn; i++) begin
        v = 8'($urandom);
        if (i < rn - 1) v[7] = 1'b1;
        else if (rn < rmb || $urandom_range(0, 1) == 0) v[7] = 1'b0;
        cur_b[8*i +: 8] = v;
      end
      rise_extra = $urandom_range(0, 2);
      fall_extra = $urandom_range(0, 2);
      start_pc = $urandom;
      model(rs32, rsg, start_pc, rn, m_imm, m_err, m_cnt, m_npc);
      run(rs32, rsg, start_pc, rn, 0, g_imm, g_err, g_cnt, g_npc, g_dcyc, g_reads, g_dones, g_busy);
      chk($sformatf("rand%0d_imm", it), g_imm, m_imm);
      chk($sformatf("rand%0d_err", it), 64'(g_err), 64'(m_err));
      chk($sformatf("rand%0d_cnt", it), 64'(g_cnt), 64'(m_cnt));
      chk($sformatf("rand%0d_npc", it), 64'(g_npc), 64'(m_npc));
      chk($sformatf("rand%0d_reads", it), 64'(g_reads), 64'(m_cnt));
      chk($sformatf("rand%0d_dones", it), 64'(g_dones), 64'd1);
    end

    chk("request_protocol", 64'(proto_bad), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
